// File: rtl/uart_tx_ctrl_pkg.sv
// Shared UART definitions: line-rate defaults, baud divider derivation and TX state encoding.
package uart_pkg;

  localparam int DEF_CLK_FREQ_HZ = 50_000_000;
  localparam int DEF_BAUD_RATE   = 115200;

  // Integer truncation is intentional: the bit period rounds down to whole clocks.
  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  localparam int DEF_BAUD_DIV = baud_div(DEF_CLK_FREQ_HZ, DEF_BAUD_RATE);

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Byte handshake between the TX FIFO (master) and the UART transmit controller (slave).
interface uart_tx_ctrl_if;

  logic [7:0] tx_fifo_data;
  logic       tx_fifo_valid;
  logic       tx_fifo_ready;

  modport master (
    output tx_fifo_data,
    output tx_fifo_valid,
    input  tx_fifo_ready
  );

  modport slave (
    input  tx_fifo_data,
    input  tx_fifo_valid,
    output tx_fifo_ready
  );

endinterface

// File: rtl/uart_tx_ctrl_baud_tick.sv
// Bit-period counter with synchronous clear; tick marks the last clock of each bit.
// Shared between the TX and RX paths.
module uart_baud_tick #(
  parameter int BAUD_DIV = 434
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic clr,
  output logic tick
);

  localparam int             CW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: pops bytes from the TX FIFO and serializes 8N1 frames,
// or 8E1 frames when UART_TX_PARITY_EN is defined.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
  parameter int BAUD_RATE   = DEF_BAUD_RATE
) (
  input  logic           aclk,
  input  logic           aresetn,
  uart_tx_ctrl_if.slave  fifo_if,
  output logic           tx_serial,
  output logic           tx_busy
);

  localparam int BAUD_DIV = baud_div(CLK_FREQ_HZ, BAUD_RATE);

  tx_state_t  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       serial_q, serial_d;
  logic       tick;
  logic       baud_clr;
  logic       idle;
`ifdef UART_TX_PARITY_EN
  logic       parity_q, parity_d;
`endif

  assign idle                  = (state_q == TX_IDLE);
  assign fifo_if.tx_fifo_ready = idle;
  assign tx_busy               = !idle;
  assign tx_serial             = serial_q;
  // Holding the counter clear through idle also gives the required clear on the handshake edge.
  assign baud_clr              = idle;

  uart_baud_tick #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_tick (
    .aclk    (aclk),
    .aresetn (aresetn),
    .clr     (baud_clr),
    .tick    (tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    serial_d  = serial_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      TX_IDLE: begin
        serial_d = 1'b1;
        if (fifo_if.tx_fifo_valid) begin
          shift_d  = fifo_if.tx_fifo_data;
`ifdef UART_TX_PARITY_EN
          parity_d = ^fifo_if.tx_fifo_data;
`endif
          serial_d = 1'b0;
          state_d  = TX_START;
        end
      end
      TX_START: begin
        if (tick) begin
          bit_idx_d = 3'd0;
          serial_d  = shift_q[0];
          state_d   = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tick) begin
          if (bit_idx_q != 3'd7) begin
            bit_idx_d = bit_idx_q + 3'd1;
            serial_d  = shift_q[bit_idx_d];
          end else begin
`ifdef UART_TX_PARITY_EN
            serial_d = parity_q;
            state_d  = TX_PARITY;
`else
            serial_d = 1'b1;
            state_d  = TX_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      TX_PARITY: begin
        if (tick) begin
          serial_d = 1'b1;
          state_d  = TX_STOP;
        end
      end
`endif
      TX_STOP: begin
        if (tick) begin
          serial_d = 1'b1;
          state_d  = TX_IDLE;
        end
      end
      default: begin
        serial_d = 1'b1;
        state_d  = TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= TX_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      serial_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      serial_q  <= serial_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: directed frames, bit-centre decoding monitor with expected-byte queue.
module tb_uart_tx_ctrl;
  import uart_pkg::*;

  localparam int BD = DEF_BAUD_DIV;
`ifdef UART_TX_PARITY_EN
  localparam int NR       = 11;
  localparam int N_FRAMES = 9;
`else
  localparam int NR       = 10;
  localparam int N_FRAMES = 7;
`endif

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  logic tx_serial;
  logic tx_busy;

  uart_tx_ctrl_if fifo_if ();

  uart_tx_ctrl dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .fifo_if   (fifo_if),
    .tx_serial (tx_serial),
    .tx_busy   (tx_busy)
  );

  always #10 aclk = ~aclk;

  int cyc     = 0;
  int rst_cnt = 0;
  always @(posedge aclk) cyc <= cyc + 1;
  always @(negedge aresetn) rst_cnt <= rst_cnt + 1;

  int tests     = 0;
  int fails     = 0;
  int frames_ok = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge aclk);
  endtask

  function automatic logic lvl(input logic [7:0] b, input int n);
    if (n == 0) return 1'b0;
    if (n <= 8) return b[n-1];
    if (NR == 11 && n == 9) return ^b;
    return 1'b1;
  endfunction

  // Called at a negedge; returns at the negedge right after the handshake edge (cyc == t).
  task automatic send_hs(input logic [7:0] b, output int t);
    int budget;
    budget = 0;
    t = -1;
    fifo_if.tx_fifo_data  = b;
    fifo_if.tx_fifo_valid = 1'b1;
    while (fifo_if.tx_fifo_ready !== 1'b1 && budget < 20000) begin
      @(negedge aclk);
      budget++;
    end
    if (fifo_if.tx_fifo_ready !== 1'b1) begin
      chk("handshake_timeout", {31'b0, fifo_if.tx_fifo_ready}, 32'd1);
    end else begin
      t = cyc + 1;
      exp_q.push_back(b);
      @(negedge aclk);
    end
  endtask

  // First and last clock of every bit region, then the return of ready.
  task automatic check_levels(input int t, input logic [7:0] b, input string name);
    for (int n = 0; n < NR; n++) begin
      wait_until(t + n * BD);
      chk($sformatf("%s_bit%0d_first", name, n), {31'b0, tx_serial}, {31'b0, lvl(b, n)});
      wait_until(t + (n + 1) * BD - 1);
      chk($sformatf("%s_bit%0d_last", name, n), {31'b0, tx_serial}, {31'b0, lvl(b, n)});
    end
    chk({name, "_ready_before_end"}, {31'b0, fifo_if.tx_fifo_ready}, 32'd0);
    wait_until(t + NR * BD);
    chk({name, "_ready_at_end"}, {31'b0, fifo_if.tx_fifo_ready}, 32'd1);
  endtask

  task automatic wait_mon(input int c, input int r0);
    while (cyc < c && rst_cnt == r0) @(negedge aclk);
  endtask

  // Monitor: detect start edges, sample each bit at its centre, compare against the queue.
  initial begin : monitor
    logic       prev;
    logic [7:0] rx, exp_b;
    logic       st, par, stp;
    int         s, r0;
    prev = 1'b1;
    par  = 1'b0;
    forever begin
      @(negedge aclk);
      if (aresetn && prev && !tx_serial) begin
        s  = cyc;
        r0 = rst_cnt;
        rx = '0;
        wait_mon(s + BD / 2, r0);
        st = tx_serial;
        for (int n = 1; n <= 8; n++) begin
          wait_mon(s + n * BD + BD / 2, r0);
          rx[n-1] = tx_serial;
        end
        if (NR == 11) begin
          wait_mon(s + 9 * BD + BD / 2, r0);
          par = tx_serial;
        end
        wait_mon(s + (NR - 1) * BD + BD / 2, r0);
        stp = tx_serial;
        if (rst_cnt != r0) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else if (exp_q.size() == 0) begin
          chk("unexpected_frame", {24'b0, rx}, 32'hFFFF_FFFF);
        end else begin
          exp_b = exp_q.pop_front();
          chk("frame_start_bit", {31'b0, st}, 32'd0);
          chk("frame_byte", {24'b0, rx}, {24'b0, exp_b});
          chk("frame_stop_bit", {31'b0, stp}, 32'd1);
          if (NR == 11) chk("frame_parity", {31'b0, par}, {31'b0, ^exp_b});
          frames_ok++;
        end
      end
      prev = tx_serial;
    end
  end

  initial begin : stimulus
    int t, t2;
    fifo_if.tx_fifo_data  = 8'h00;
    fifo_if.tx_fifo_valid = 1'b0;
    repeat (3) @(negedge aclk);
    chk("reset_serial", {31'b0, tx_serial}, 32'd1);
    chk("reset_ready", {31'b0, fifo_if.tx_fifo_ready}, 32'd1);
    chk("reset_busy", {31'b0, tx_busy}, 32'd0);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);

    // Alternating pattern with exact bit lengths
    send_hs(8'h55, t);
    fifo_if.tx_fifo_valid = 1'b0;
    chk("busy_after_hs", {31'b0, tx_busy}, 32'd1);
    check_levels(t, 8'h55, "f55");

    // All-zero then all-one, back to back
    send_hs(8'h00, t);
    fifo_if.tx_fifo_data = 8'hFF;
    check_levels(t, 8'h00, "f00");
    send_hs(8'hFF, t2);
    fifo_if.tx_fifo_valid = 1'b0;
    chk("gap_00_ff", t2 - t, NR * BD + 1);
    check_levels(t2, 8'hFF, "fFF");

    // Back-to-back with valid held high
    send_hs(8'hA5, t);
    fifo_if.tx_fifo_data = 8'h3C;
    send_hs(8'h3C, t2);
    fifo_if.tx_fifo_valid = 1'b0;
    chk("gap_a5_3c", t2 - t, NR * BD + 1);
    wait_until(t2 + NR * BD + 1);

    // Data wiggles while busy with valid held: no extra handshake, byte unchanged
    send_hs(8'h96, t);
    for (int k = 1; k < NR; k++) begin
      wait_until(t + k * BD);
      fifo_if.tx_fifo_data = 8'($urandom);
      chk($sformatf("busy_ready_low_%0d", k), {31'b0, fifo_if.tx_fifo_ready}, 32'd0);
    end
    wait_until(t + NR * BD - 1);
    fifo_if.tx_fifo_valid = 1'b0;
    wait_until(t + NR * BD + 2);
    chk("no_extra_handshake", {31'b0, tx_busy}, 32'd0);

    // Asynchronous reset in the middle of data bit 3
    send_hs(8'h81, t);
    fifo_if.tx_fifo_valid = 1'b0;
    wait_until(t + 4 * BD + 100);
    #3 aresetn = 1'b0;
    #1;
    chk("midreset_serial", {31'b0, tx_serial}, 32'd1);
    chk("midreset_ready", {31'b0, fifo_if.tx_fifo_ready}, 32'd1);
    chk("midreset_busy", {31'b0, tx_busy}, 32'd0);
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    send_hs(8'h42, t);
    fifo_if.tx_fifo_valid = 1'b0;
    wait_until(t + NR * BD + 2);

`ifdef UART_TX_PARITY_EN
    send_hs(8'h07, t);
    fifo_if.tx_fifo_valid = 1'b0;
    check_levels(t, 8'h07, "p07");
    wait_until(t + NR * BD + 2);
    send_hs(8'h03, t);
    fifo_if.tx_fifo_valid = 1'b0;
    check_levels(t, 8'h03, "p03");
    wait_until(t + NR * BD + 2);
`endif

    chk("queue_drained", exp_q.size(), 32'd0);
    chk("frames_decoded", frames_ok, N_FRAMES);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
